pbit_cell: RTL and testbench

- Single probabilistic bit (p-bit) for the Ising-style probabilistic network. Each network node has one instance.
- Takes a precomputed signed fixed-point input current I_i and maps it through a tanh lookup.
- Compares the result against a pseudo-random number from a private 32-bit LFSR and registers the stochastic binary state m_i.
- The group sequencer drives enable; the neighbouring cells read m_i.

---
 rtl/pbit_cell.sv | 85 ++++++++
 tb/tb_pbit_cell.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pbit_cell.sv
// Probabilistic bit: tanh-mapped input current compared against a private
// 32-bit Galois LFSR sample to produce a registered stochastic state.
module pbit_cell #(
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic signed [7:0] I_i,
  input  logic [31:0]       seed,
  output logic              m_i,
  output logic [7:0]        rnd
);

  localparam int unsigned LFSR_W   = 32;
  localparam int unsigned DATA_W   = 8;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;

  logic [LFSR_W-1:0]        lfsr;
  logic [LFSR_W-1:0]        lfsr_next_c;
  logic [DATA_W-1:0]        mag_c;
  logic [DATA_W-2:0]        tmag_c;
  logic signed [DATA_W-1:0] t_c;
  logic signed [DATA_W-1:0] r_c;
  logic                     take_c;

  // Magnitude of the input; -128 yields 128, which falls into the saturated range.
  always_comb begin
    mag_c = I_i[7] ? DATA_W'(8'd0 - $unsigned(I_i)) : $unsigned(I_i);
  end

  // Half table of round(127*tanh(x/8)) for x = 0..24; 127 from 25 upward.
  always_comb begin
    tmag_c = 7'd127;
    case (mag_c)
      8'd0:  tmag_c = 7'd0;
      8'd1:  tmag_c = 7'd16;
      8'd2:  tmag_c = 7'd31;
      8'd3:  tmag_c = 7'd46;
      8'd4:  tmag_c = 7'd59;
      8'd5:  tmag_c = 7'd70;
      8'd6:  tmag_c = 7'd81;
      8'd7:  tmag_c = 7'd89;
      8'd8:  tmag_c = 7'd97;
      8'd9:  tmag_c = 7'd103;
      8'd10: tmag_c = 7'd108;
      8'd11: tmag_c = 7'd112;
      8'd12: tmag_c = 7'd115;
      8'd13: tmag_c = 7'd118;
      8'd14: tmag_c = 7'd120;
      8'd15: tmag_c = 7'd121;
      8'd16: tmag_c = 7'd122;
      8'd17: tmag_c = 7'd123;
      8'd18: tmag_c = 7'd124;
      8'd19: tmag_c = 7'd125;
      8'd20: tmag_c = 7'd125;
      8'd21: tmag_c = 7'd126;
      8'd22: tmag_c = 7'd126;
      8'd23: tmag_c = 7'd126;
      8'd24: tmag_c = 7'd126;
      default: tmag_c = 7'd127;
    endcase
  end

  // Odd-symmetric reconstruction, random sample and decision.
  always_comb begin
    t_c         = I_i[7] ? DATA_W'(-$signed({1'b0, tmag_c})) : $signed({1'b0, tmag_c});
    r_c         = $signed(lfsr[DATA_W-1:0]);
    take_c      = (t_c >= r_c);
    lfsr_next_c = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : LFSR_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      lfsr <= (seed == LFSR_W'(0)) ? SEED_DEFAULT : seed;
      m_i  <= 1'b0;
    end else if (enable) begin
      lfsr <= lfsr_next_c;
      m_i  <= take_c;
    end
  end

  assign rnd = lfsr[DATA_W-1:0];

endmodule

// File: tb/tb_pbit_cell.sv
// Directed bench for pbit_cell: seed load, hand-computed tanh points,
// hold, saturation, statistics and mid-run reset.
module tb_pbit_cell;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic signed [7:0] I_i;
  logic [31:0]       seed;
  logic              m_i;
  logic [7:0]        rnd;

  int          n_checks;
  int          n_fail;
  logic [31:0] mdl;
  logic        exp_m;

  pbit_cell dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .I_i    (I_i),
    .seed   (seed),
    .m_i    (m_i),
    .rnd    (rnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reset for one edge with the given seed, then release with a scrambled seed.
  task automatic do_reset(input logic [31:0] s);
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b0;
    seed    = s;
    @(posedge clk);
    #1;
    mdl   = (s == 32'd0) ? 32'd1 : s;
    exp_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    seed    = 32'hDEAD_BEEF;
  endtask

  // One cycle; t is the hand-computed tanh value for x. Inputs change on negedge.
  task automatic step(input logic en, input logic signed [7:0] x, input int t);
    int r;
    if (clk) @(negedge clk);
    enable = en;
    I_i    = x;
    r      = int'($signed(mdl[7:0]));
    if (en) begin
      exp_m = (t >= r);
      mdl   = (mdl >> 1) ^ (mdl[0] ? 32'h8020_0003 : 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic signed [7:0] x;
    int                t;
  } tpoint_t;

  tpoint_t pts[12];
  logic    rec_m[16];
  logic [7:0] rec_r[16];
  int      ones;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    enable   = 1'b0;
    I_i      = 8'sd0;
    seed     = 32'd1;
    mdl      = 32'd1;
    exp_m    = 1'b0;

    pts[0]  = '{8'sd0,     0};
    pts[1]  = '{8'sd8,     97};
    pts[2]  = '{-8'sd8,   -97};
    pts[3]  = '{8'sd4,     59};
    pts[4]  = '{8'sd16,    122};
    pts[5]  = '{8'sd127,   127};
    pts[6]  = '{-8'sd128, -127};
    pts[7]  = '{8'sd1,     16};
    pts[8]  = '{-8'sd3,   -46};
    pts[9]  = '{8'sd24,    126};
    pts[10] = '{8'sd12,    115};
    pts[11] = '{-8'sd5,   -70};

    // Seed load and first two deterministic decisions
    do_reset(32'd1);
    check("rst_m", 32'(m_i), 32'd0);
    check("rst_rnd", 32'(rnd), 32'h01);
    step(1'b1, 8'sd0, 0);
    check("c1_m", 32'(m_i), 32'd0);
    check("c1_rnd", 32'(rnd), 32'h03);
    step(1'b1, 8'sd8, 97);
    check("c2_m", 32'(m_i), 32'd1);
    check("c2_rnd", 32'(rnd), 32'h02);

    // Zero seed falls back to the default
    do_reset(32'd0);
    check("z_rst_m", 32'(m_i), 32'd0);
    check("z_rst_rnd", 32'(rnd), 32'h01);
    step(1'b1, 8'sd0, 0);
    check("z_c1_m", 32'(m_i), 32'd0);
    check("z_c1_rnd", 32'(rnd), 32'h03);
    step(1'b1, 8'sd8, 97);
    check("z_c2_m", 32'(m_i), 32'd1);
    check("z_c2_rnd", 32'(rnd), 32'h02);

    // Hold with enable low while I_i toggles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i % 2 == 0) ? -8'sd128 : 8'sd127, 0);
      check("hold_m", 32'(m_i), 32'd1);
      check("hold_rnd", 32'(rnd), 32'h02);
    end

    // tanh points against the reference LFSR sample
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < 20; k++) begin
        step(1'b1, pts[p].x, pts[p].t);
        check($sformatf("pt%0d_m", p), 32'(m_i), 32'(exp_m));
        check($sformatf("pt%0d_rnd", p), 32'(rnd), mdl & 32'hFF);
      end
    end

    // Positive saturation
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 8'sd127, 127);
      check("sat_pos", 32'(m_i), 32'd1);
    end

    // Negative saturation
    ones = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, -8'sd128, -127);
      ones += int'(m_i);
      check("sat_neg_m", 32'(m_i), 32'(exp_m));
    end
    check("sat_neg_ones_le30", 32'(ones <= 30), 32'd1);

    // Statistics at I=0 (p=0.504) and I=8 (p=0.883)
    ones = 0;
    for (int k = 0; k < 4096; k++) begin
      step(1'b1, 8'sd0, 0);
      ones += int'(m_i);
    end
    check("stat0_range", 32'(ones >= 1942 && ones <= 2187), 32'd1);
    ones = 0;
    for (int k = 0; k < 4096; k++) begin
      step(1'b1, 8'sd8, 97);
      ones += int'(m_i);
    end
    check("stat8_range", 32'(ones >= 3494 && ones <= 3739), 32'd1);

    // Mid-run reset: record a run, pulse reset under enable, replay
    do_reset(32'd1);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k % 2 == 0) ? 8'sd8 : 8'sd0, (k % 2 == 0) ? 97 : 0);
      rec_m[k] = m_i;
      rec_r[k] = rnd;
      check("rec_m", 32'(m_i), 32'(exp_m));
    end
    for (int k = 0; k < 5; k++) step(1'b1, 8'sd127, 127);
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    I_i     = 8'sd127;
    seed    = 32'd1;
    @(posedge clk);
    #1;
    mdl = 32'd1;
    check("mid_rst_m", 32'(m_i), 32'd0);
    check("mid_rst_rnd", 32'(rnd), 32'h01);
    @(negedge clk);
    reset_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k % 2 == 0) ? 8'sd8 : 8'sd0, (k % 2 == 0) ? 97 : 0);
      check("replay_m", 32'(m_i), 32'(rec_m[k]));
      check("replay_rnd", 32'(rnd), 32'(rec_r[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
